// File: rtl/int_sequencer_pkg.sv
// int_sequencer_pkg: shared constants and FSM state type for the interrupt sequencer
package int_sequencer_pkg;
  localparam int NSRC = 4;
  localparam int IDXW = $clog2(NSRC);
  localparam logic [31:0] VEC_BASE = 32'hFFFF_FFFC;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
endpackage

// File: rtl/int_sequencer_if.sv
// int_sequencer_if: accelerator/CPU-side signals of the interrupt sequencer
interface int_sequencer_if;
  import int_sequencer_pkg::*;
  logic [NSRC-1:0] done;
  logic int_ack;
  logic isr_done;
  logic cfg_we;
  logic [NSRC-1:0] cfg_mask;
  logic int_req;
  logic [31:0] int_addr;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] overrun;
  logic [NSRC-1:0] in_service;
  modport master (
    output done, int_ack, isr_done, cfg_we, cfg_mask,
    input int_req, int_addr, pending, overrun, in_service
  );
  modport slave (
    input done, int_ack, isr_done, cfg_we, cfg_mask,
    output int_req, int_addr, pending, overrun, in_service
  );
endinterface

// File: rtl/int_sequencer_prio_enc.sv
// int_prio_enc: index of the highest set request bit plus an any-set flag
module int_prio_enc
  import int_sequencer_pkg::*;
(
  input  logic [NSRC-1:0] req,
  output logic [IDXW-1:0] idx,
  output logic            valid
);
  // ascending scan so the highest set bit is written last and wins
  always_comb begin
    idx = '0;
    for (int i = 0; i < NSRC; i++) idx = req[i] ? IDXW'(i) : idx;
  end
  assign valid = |req;
endmodule

// File: rtl/int_sequencer.sv
// int_sequencer: edge-captured, masked, prioritised interrupt request/ack/service sequencer
module int_sequencer
  import int_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  int_sequencer_if.slave   bus
);
  state_t state, state_n;
  logic [NSRC-1:0] done_q, pending, overrun, mask, in_service, rise, elig, clr;
  logic [IDXW-1:0] vec_idx, vec_idx_n, enc_idx;
  logic enc_valid, ack_fire;
  assign rise = bus.done & ~done_q;
  assign elig = pending & ~mask;
  assign clr  = ack_fire ? NSRC'(1) << vec_idx : '0;
  int_prio_enc u_enc (.req(elig), .idx(enc_idx), .valid(enc_valid));
  // next state and vector: track the winner while requesting, freeze it on ack
  always_comb begin
    state_n   = state;
    vec_idx_n = vec_idx;
    ack_fire  = 1'b0;
    case (state)
      IDLE: begin
        state_n   = enc_valid ? REQ : IDLE;
        vec_idx_n = enc_valid ? enc_idx : vec_idx;
      end
      REQ: begin
        ack_fire  = bus.int_ack;
        state_n   = bus.int_ack ? SERVICE : enc_valid ? REQ : IDLE;
        vec_idx_n = (!bus.int_ack && enc_valid) ? enc_idx : vec_idx;
      end
      SERVICE: state_n = bus.isr_done ? IDLE : SERVICE;
      default: state_n = IDLE;
    endcase
  end
  // registers: a new edge beats the ack clear of the same source
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec_idx    <= '0;
      done_q     <= '0;
      pending    <= '0;
      overrun    <= '0;
      mask       <= '0;
      in_service <= '0;
    end else begin
      state      <= state_n;
      vec_idx    <= vec_idx_n;
      done_q     <= bus.done;
      pending    <= (pending & ~clr) | rise;
      overrun    <= (overrun & ~clr) | (rise & pending & ~clr);
      mask       <= bus.cfg_we ? bus.cfg_mask : mask;
      in_service <= ack_fire ? clr : (state == SERVICE && bus.isr_done) ? '0 : in_service;
    end
  end
  assign bus.int_req    = state == REQ;
  assign bus.int_addr   = state == IDLE ? '0 : {VEC_BASE[31:IDXW], vec_idx};
  assign bus.pending    = pending;
  assign bus.overrun    = overrun;
  assign bus.in_service = in_service;
endmodule

// File: tb/tb_int_sequencer.sv
// tb_int_sequencer: directed-vector self-checking bench for int_sequencer
module tb_int_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int_sequencer_if bus();
  int_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask
  task automatic isr();
    bus.isr_done = 1'b1;
    tick();
    bus.isr_done = 1'b0;
  endtask
  initial begin
    bus.done = '0;
    bus.int_ack = 1'b0;
    bus.isr_done = 1'b0;
    bus.cfg_we = 1'b0;
    bus.cfg_mask = '0;
    tick(2);
    check("rst_req", 32'(bus.int_req), 32'd0);
    check("rst_addr", bus.int_addr, 32'h0);
    check("rst_pend", 32'(bus.pending), 32'h0);
    check("rst_ovr", 32'(bus.overrun), 32'h0);
    check("rst_insvc", 32'(bus.in_service), 32'h0);
    rst_n = 1'b1;
    tick();
    // 1: single source latency
    bus.done = 4'b0010;
    tick();
    check("t1_pend", 32'(bus.pending), 32'h2);
    check("t1_req_early", 32'(bus.int_req), 32'd0);
    tick();
    check("t1_req", 32'(bus.int_req), 32'd1);
    check("t1_addr", bus.int_addr, 32'hFFFF_FFFD);
    bus.done = '0;
    ack();
    check("t1_insvc", 32'(bus.in_service), 32'h2);
    check("t1_req_svc", 32'(bus.int_req), 32'd0);
    check("t1_addr_svc", bus.int_addr, 32'hFFFF_FFFD);
    isr();
    check("t1_idle_insvc", 32'(bus.in_service), 32'h0);
    check("t1_idle_addr", bus.int_addr, 32'h0);
    // 2: simultaneous edges, priority and re-request
    bus.done = 4'b0101;
    tick(2);
    bus.done = '0;
    check("t2_addr", bus.int_addr, 32'hFFFF_FFFE);
    ack();
    check("t2_pend", 32'(bus.pending), 32'h1);
    check("t2_insvc", 32'(bus.in_service), 32'h4);
    isr();
    check("t2_gap", 32'(bus.int_req), 32'd0);
    tick();
    check("t2_rereq", 32'(bus.int_req), 32'd1);
    check("t2_readdr", bus.int_addr, 32'hFFFF_FFFC);
    // 3: higher priority arrives before ack
    bus.done = 4'b1000;
    tick();
    bus.done = '0;
    check("t3_addr_old", bus.int_addr, 32'hFFFF_FFFC);
    tick();
    check("t3_addr_new", bus.int_addr, 32'hFFFF_FFFF);
    ack();
    check("t3_insvc", 32'(bus.in_service), 32'h8);
    check("t3_pend", 32'(bus.pending), 32'h1);
    isr();
    tick();
    check("t3_src0", bus.int_addr, 32'hFFFF_FFFC);
    ack();
    isr();
    // 4: masked event held, released by unmask
    bus.cfg_we = 1'b1;
    bus.cfg_mask = 4'b0010;
    tick();
    bus.cfg_we = 1'b0;
    bus.done = 4'b0010;
    tick();
    bus.done = '0;
    tick(2);
    check("t4_pend", 32'(bus.pending), 32'h2);
    check("t4_masked", 32'(bus.int_req), 32'd0);
    bus.cfg_we = 1'b1;
    bus.cfg_mask = '0;
    tick();
    bus.cfg_we = 1'b0;
    check("t4_wr_cycle", 32'(bus.int_req), 32'd0);
    tick();
    check("t4_req", 32'(bus.int_req), 32'd1);
    check("t4_addr", bus.int_addr, 32'hFFFF_FFFD);
    ack();
    isr();
    // 5: coalesced edges during service set overrun
    bus.done = 4'b0100;
    tick();
    bus.done = '0;
    tick();
    ack();
    check("t5_svc", 32'(bus.in_service), 32'h4);
    for (int i = 0; i < 2; i++) begin
      bus.done = 4'b0100;
      tick();
      bus.done = '0;
      tick();
    end
    check("t5_pend", 32'(bus.pending), 32'h4);
    check("t5_ovr", 32'(bus.overrun), 32'h4);
    check("t5_nonest", 32'(bus.int_req), 32'd0);
    isr();
    tick();
    check("t5_addr", bus.int_addr, 32'hFFFF_FFFE);
    ack();
    check("t5_pend_clr", 32'(bus.pending), 32'h0);
    check("t5_ovr_clr", 32'(bus.overrun), 32'h0);
    isr();
    // 6: reset mid-request, then stray ack/isr_done in IDLE
    bus.done = 4'b1001;
    tick();
    bus.done = '0;
    tick();
    check("t6_req", 32'(bus.int_req), 32'd1);
    check("t6_pend", 32'(bus.pending), 32'h9);
    rst_n = 1'b0;
    tick();
    check("t6_rst_req", 32'(bus.int_req), 32'd0);
    check("t6_rst_addr", bus.int_addr, 32'h0);
    check("t6_rst_pend", 32'(bus.pending), 32'h0);
    rst_n = 1'b1;
    tick();
    bus.int_ack = 1'b1;
    bus.isr_done = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.isr_done = 1'b0;
    tick();
    check("t6_stray_req", 32'(bus.int_req), 32'd0);
    check("t6_stray_insvc", 32'(bus.in_service), 32'h0);
    check("t6_stray_addr", bus.int_addr, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
